serial_subtractor4: RTL and testbench
=====================================

SERIAL_SUBTRACTOR4 -- requirements
Module: serial_subtractor4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits; the only supported value is 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin one subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend, captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend, captured when start is accepted.
REQ-007 The block SHALL have port diff, output, WIDTH bits: (a - b) mod 2^WIDTH.
REQ-008 The block SHALL have port borrow, output, 1 bit: final borrow-out, 1 iff a < b unsigned.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a subtraction is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking diff/borrow valid.

Function
REQ-011 The FSM SHALL have three states, IDLE, SHIFT and DONE, encoded in the shared package.
REQ-012 In IDLE with start=1 at edge N, the block SHALL capture a and b into shift registers, clear the borrow flop and the bit counter, and enter SHIFT with busy=1 at edge N.
REQ-013 In IDLE with start=0, the block SHALL stay in IDLE and hold diff/borrow at their last values.
REQ-014 In SHIFT, each edge SHALL process one bit pair, LSB first, through one full-subtractor cell: d = x^y^bin; bout = (~x&y) | (~(x^y)&bin).
REQ-015 On each SHIFT edge, the result bit SHALL shift into diff from the MSB end, bout SHALL register as the next bin, and the counter SHALL increment.
REQ-016 After the edge that processes bit WIDTH-1 (edge N+4), the block SHALL be in DONE with done=1, busy=0, and diff and borrow final.
REQ-017 From DONE, the next edge (N+5) SHALL return the block to IDLE with done=0; diff/borrow SHALL hold until the next accepted start.
REQ-018 Total latency SHALL be WIDTH+1 edges from start acceptance to done; the minimum start-to-start interval SHALL be WIDTH+2 edges.
REQ-019 The block SHALL ignore start while in SHIFT or DONE, so that operands in flight are unaffected.
REQ-020 start held high continuously SHALL yield back-to-back operations, each starting at the edge where the block is in IDLE.
REQ-021 The counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap during SHIFT; the state exits SHIFT at count WIDTH-1.
REQ-022 The block SHALL sample no a or b values other than those present at the accepting edge.

Reset
REQ-023 On rst_n=0, at any time including mid-SHIFT, the block SHALL immediately force state=IDLE, diff=0, borrow=0, busy=0, done=0, counter=0 and the shift registers to 0.
REQ-024 After rst_n deasserts, the first start SHALL be accepted no earlier than the first rising edge with rst_n=1; a partial operation SHALL never resume.

Structure
REQ-025 A shared package SHALL hold the state enum (IDLE, SHIFT, DONE) and the WIDTH default constant.
REQ-026 The 1-bit cell SHALL be one sub-module, full_subtractor (ports x, y, bin, d, bout), built in gate-level modelling.
REQ-027 The top level SHALL contain only the FSM, the counter, the shift registers and the borrow flop.

Verification
REQ-028 The bench SHALL drive a=5, b=3, start pulse -> diff=2, borrow=0, done=1 exactly 5 edges after acceptance.
REQ-029 The bench SHALL drive a=3, b=5 -> diff=14 (1110), borrow=1; a=0, b=1 -> diff=15, borrow=1.
REQ-030 The bench SHALL drive a=15, b=15 -> diff=0, borrow=0; a=15, b=0 -> diff=15, borrow=0.
REQ-031 The bench SHALL drive a=9, b=4, then change to a=1, b=7 with start pulsed during SHIFT -> result diff=5, borrow=0, and the second start ignored.
REQ-032 The bench SHALL drive a=12, b=3 and assert rst_n=0 after 2 SHIFT edges -> all outputs 0 immediately, and after release a=12, b=3 -> diff=9, borrow=0.
REQ-033 The bench SHALL run an exhaustive 256-pair sweep with start held high -> every done pulse matches a-b mod 16 and a<b, with 6 edges between done pulses.

Source files
------------

// File: rtl/serial_subtractor4_pkg.sv
// Shared constants and FSM encoding for the bit-serial 4-bit subtractor.
package serial_subtractor4_pkg;
  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/serial_subtractor4_full_subtractor.sv
// One-bit full subtractor cell: d = x^y^bin, bout = (~x&y) | (~(x^y)&bin).
module full_subtractor (
  input  wire x,
  input  wire y,
  input  wire bin,
  output wire d,
  output wire bout
);
  wire xy, nx, nxy, t1, t2;

  xor g_xy  (xy, x, y);
  xor g_d   (d, xy, bin);
  not g_nx  (nx, x);
  and g_t1  (t1, nx, y);
  not g_nxy (nxy, xy);
  and g_t2  (t2, nxy, bin);
  or  g_bo  (bout, t1, t2);
endmodule

// File: rtl/serial_subtractor4.sv
// Bit-serial subtractor: one bit pair per clock, LSB first, through a single cell.
module serial_subtractor4
  import serial_subtractor4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0]    cnt;
  logic             d_bit, bout_bit;

  // The borrow flop doubles as the cell's borrow-in and the final borrow output.
  full_subtractor u_cell (
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (bout_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            cnt    <= '0;
            borrow <= 1'b0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          diff   <= {d_bit, diff[WIDTH-1:1]};
          borrow <= bout_bit;
          if (cnt == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor4.sv
// Self-checking bench: directed vectors, corner sequences, random ops and a full sweep.
module tb_serial_subtractor4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic [3:0] diff;
  logic       borrow, busy, done;

  int checks = 0;
  int errors = 0;

  serial_subtractor4 #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .diff(diff), .borrow(borrow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] va, vb;
    logic [3:0] ed;
    logic       eb;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int ref_diff(input int x, input int y);
    return (x - y + 16) % 16;
  endfunction

  function automatic int ref_borrow(input int x, input int y);
    return (x < y) ? 1 : 0;
  endfunction

  // Pulse start with the operands, then count edges from acceptance to done.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_,
                        output logic [3:0] rd, output logic rb, output int lat);
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    rd = diff; rb = borrow;
    chk("busy_low_at_done", int'(busy), 0);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    vec_t vecs[5];
    logic [3:0] rd;
    logic       rb;
    int         lat;

    vecs[0] = '{va: 4'd5,  vb: 4'd3,  ed: 4'd2,  eb: 1'b0};
    vecs[1] = '{va: 4'd3,  vb: 4'd5,  ed: 4'd14, eb: 1'b1};
    vecs[2] = '{va: 4'd0,  vb: 4'd1,  ed: 4'd15, eb: 1'b1};
    vecs[3] = '{va: 4'd15, vb: 4'd15, ed: 4'd0,  eb: 1'b0};
    vecs[4] = '{va: 4'd15, vb: 4'd0,  ed: 4'd15, eb: 1'b0};

    #1;
    chk("reset_diff", int'(diff), 0);
    chk("reset_borrow", int'(borrow), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].va, vecs[i].vb, rd, rb, lat);
      chk($sformatf("vec%0d_latency", i), lat, 5);
      chk($sformatf("vec%0d_diff", i), int'(rd), int'(vecs[i].ed));
      chk($sformatf("vec%0d_borrow", i), int'(rb), int'(vecs[i].eb));
    end

    // Hold: no start, outputs keep the last result.
    repeat (3) @(negedge clk);
    chk("hold_diff", int'(diff), 15);
    chk("hold_borrow", int'(borrow), 0);

    // Operands and start changed mid-operation must be ignored.
    @(negedge clk);
    a = 4'd9; b = 4'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 4'd1; b = 4'd7;
    repeat (2) @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk("inflight_done_seen", int'(done), 1);
    chk("inflight_diff", int'(diff), 5);
    chk("inflight_borrow", int'(borrow), 0);
    repeat (2) @(negedge clk);
    chk("inflight_second_start_ignored", int'(busy), 0);

    // Reset in the middle of SHIFT.
    @(negedge clk);
    a = 4'd12; b = 4'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_diff", int'(diff), 0);
    chk("midrst_borrow", int'(borrow), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_no_resume", int'(busy), 0);
    run_op(4'd12, 4'd3, rd, rb, lat);
    chk("postrst_latency", lat, 5);
    chk("postrst_diff", int'(rd), 9);
    chk("postrst_borrow", int'(rb), 0);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 20; i++) begin
      int ra, rbv;
      ra  = int'($urandom_range(15));
      rbv = int'($urandom_range(15));
      run_op(4'(ra), 4'(rbv), rd, rb, lat);
      chk("rand_diff", int'(rd), ref_diff(ra, rbv));
      chk("rand_borrow", int'(rb), ref_borrow(ra, rbv));
    end

    // Exhaustive sweep with start held high: new operands loaded whenever idle.
    begin
      int idx = 0, ndone = 0, last = -1, cyc = 0;
      int pa = 0, pb = 0;
      @(negedge clk);
      start = 1'b1;
      while (ndone < 256 && cyc < 4000) begin
        if (done) begin
          chk("sweep_diff", int'(diff), ref_diff(pa, pb));
          chk("sweep_borrow", int'(borrow), ref_borrow(pa, pb));
          if (last >= 0) chk("sweep_interval", cyc - last, 6);
          last = cyc;
          ndone++;
        end
        if (!busy && !done) begin
          if (idx < 256) begin
            pa = idx / 16; pb = idx % 16;
            a = 4'(pa); b = 4'(pb);
            idx++;
          end else begin
            start = 1'b0;
          end
        end
        @(negedge clk);
        cyc++;
      end
      start = 1'b0;
      chk("sweep_done_count", ndone, 256);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
